// File: rtl/ddr3_port_arbiter.sv
// ---------------------------------------------------------------------------
// ddr3_port_arbiter
//
// Shares one DDR3 controller request interface between two requesters.
// Port 0 is the CPU-bus bridge side, port 1 the secondary master (video/DMA).
// A winning request is registered onto the dram_* outputs and held there
// until the controller accepts it. The issuing port of every accepted read is
// pushed into a small FIFO so in-order read returns are steered back to the
// port that asked for them.
//
// Handshake rules (all valid/ready pairs on this block):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   Requester side: pX_valid is held with stable payload until pX_ready is
//   seen. pX_ready is a one-cycle pulse marking capture of the request. If
//   pX_valid is still high in the following cycle, that is a new request.
//   Controller side: dram_valid and the dram_* payload stay stable until
//   dram_ready is seen high.
//
// Build option:
//   DDR3_PORT_ARBITER_FIXED_PRIORITY_EN defined   : port 0 wins every contest.
//   DDR3_PORT_ARBITER_FIXED_PRIORITY_EN undefined : round-robin (default).
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   pX_address/write/valid   request from port X (X = 0, 1)
//   pX_wdata/wdata_mask      write payload from port X
//   pX_ready                 request captured (one-cycle pulse)
//   pX_rdata/rdata_valid     routed read return to port X
//   dram_*                   controller request / read-return interface
//   o_dbg_state              FSM state (0 = IDLE, 1 = ISSUE)
//   o_dbg_fifo_count         number of outstanding reads being tracked
// ---------------------------------------------------------------------------
module ddr3_port_arbiter #(
    parameter int RD_FIFO_DEPTH = 4,
    parameter int RD_FIFO_BITS  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [26:0]             p0_address,
    input  logic                    p0_write,
    input  logic                    p0_valid,
    output logic                    p0_ready,
    input  logic [127:0]            p0_wdata,
    input  logic [15:0]             p0_wdata_mask,
    output logic [127:0]            p0_rdata,
    output logic                    p0_rdata_valid,
    input  logic [26:0]             p1_address,
    input  logic                    p1_write,
    input  logic                    p1_valid,
    output logic                    p1_ready,
    input  logic [127:0]            p1_wdata,
    input  logic [15:0]             p1_wdata_mask,
    output logic [127:0]            p1_rdata,
    output logic                    p1_rdata_valid,
    output logic [26:0]             dram_address,
    output logic                    dram_write,
    output logic                    dram_valid,
    input  logic                    dram_ready,
    output logic [127:0]            dram_wdata,
    output logic [15:0]             dram_wdata_mask,
    input  logic [127:0]            dram_rdata,
    input  logic                    dram_rdata_valid,
    output logic                    o_dbg_state,
    output logic [RD_FIFO_BITS:0]   o_dbg_fifo_count
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    localparam logic [RD_FIFO_BITS:0]   LP_DEPTH   = (RD_FIFO_BITS+1)'(RD_FIFO_DEPTH);
    localparam logic [RD_FIFO_BITS:0]   LP_CNT_ONE = (RD_FIFO_BITS+1)'(1);
    localparam logic [RD_FIFO_BITS-1:0] LP_PTR_ONE = RD_FIFO_BITS'(1);

    state_t                  r_state;
    state_t                  w_next_state;
`ifndef DDR3_PORT_ARBITER_FIXED_PRIORITY_EN
    logic                    r_last_grant;
`endif
    logic                    r_grant_port;
    logic [26:0]             r_dram_address;
    logic                    r_dram_write;
    logic                    r_dram_valid;
    logic [127:0]            r_dram_wdata;
    logic [15:0]             r_dram_wdata_mask;
    logic                    r_p0_ready;
    logic                    r_p1_ready;
    logic [127:0]            r_p0_rdata;
    logic [127:0]            r_p1_rdata;
    logic                    r_p0_rdata_valid;
    logic                    r_p1_rdata_valid;

    // Read-owner FIFO: one bit per outstanding read, holding the port id.
    logic                    r_fifo [RD_FIFO_DEPTH];
    logic [RD_FIFO_BITS-1:0] r_wr_ptr;
    logic [RD_FIFO_BITS-1:0] r_rd_ptr;
    logic [RD_FIFO_BITS:0]   r_fifo_count;

    logic                    w_fifo_full;
    logic                    w_p0_elig;
    logic                    w_p1_elig;
    logic                    w_grant;
    logic                    w_grant_port;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_pop;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // ---------------- FSM: next state and grant decision ----------------
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_port = 1'b0;
        w_accept     = 1'b0;
        // A full FIFO only holds back reads; writes on either port still go.
        w_fifo_full  = (r_fifo_count == LP_DEPTH);
        w_p0_elig    = p0_valid && (p0_write || !w_fifo_full);
        w_p1_elig    = p1_valid && (p1_write || !w_fifo_full);
        case (r_state)
            S_IDLE: begin
                if (w_p0_elig && w_p1_elig) begin
                    w_grant = 1'b1;
`ifdef DDR3_PORT_ARBITER_FIXED_PRIORITY_EN
                    w_grant_port = 1'b0;
`else
                    w_grant_port = ~r_last_grant;
`endif
                end else if (w_p0_elig) begin
                    w_grant      = 1'b1;
                    w_grant_port = 1'b0;
                end else if (w_p1_elig) begin
                    w_grant      = 1'b1;
                    w_grant_port = 1'b1;
                end
                if (w_grant) w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                w_accept = r_dram_valid && dram_ready;
                if (w_accept) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        w_push = w_accept && !r_dram_write;
        // A return with nothing outstanding is an orphan and is dropped.
        w_pop  = dram_rdata_valid && (r_fifo_count != '0);
    end

    // ---------------- Command, response and FIFO pointer registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
`ifndef DDR3_PORT_ARBITER_FIXED_PRIORITY_EN
            r_last_grant      <= 1'b1;
`endif
            r_grant_port      <= 1'b0;
            r_dram_address    <= '0;
            r_dram_write      <= 1'b0;
            r_dram_valid      <= 1'b0;
            r_dram_wdata      <= '0;
            r_dram_wdata_mask <= '0;
            r_p0_ready        <= 1'b0;
            r_p1_ready        <= 1'b0;
            r_p0_rdata        <= '0;
            r_p1_rdata        <= '0;
            r_p0_rdata_valid  <= 1'b0;
            r_p1_rdata_valid  <= 1'b0;
            r_wr_ptr          <= '0;
            r_rd_ptr          <= '0;
            r_fifo_count      <= '0;
        end else begin
            r_p0_ready       <= 1'b0;
            r_p1_ready       <= 1'b0;
            r_p0_rdata_valid <= 1'b0;
            r_p1_rdata_valid <= 1'b0;

            if (w_grant) begin
                r_dram_address    <= w_grant_port ? p1_address    : p0_address;
                r_dram_write      <= w_grant_port ? p1_write      : p0_write;
                r_dram_wdata      <= w_grant_port ? p1_wdata      : p0_wdata;
                r_dram_wdata_mask <= w_grant_port ? p1_wdata_mask : p0_wdata_mask;
                r_dram_valid      <= 1'b1;
                r_p0_ready        <= ~w_grant_port;
                r_p1_ready        <= w_grant_port;
                r_grant_port      <= w_grant_port;
`ifndef DDR3_PORT_ARBITER_FIXED_PRIORITY_EN
                r_last_grant      <= w_grant_port;
`endif
            end

            if (w_accept) begin
                r_dram_valid <= 1'b0;
                r_dram_write <= 1'b0;
            end

            if (w_push) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
                if (r_fifo[r_rd_ptr]) begin
                    r_p1_rdata       <= dram_rdata;
                    r_p1_rdata_valid <= 1'b1;
                end else begin
                    r_p0_rdata       <= dram_rdata;
                    r_p0_rdata_valid <= 1'b1;
                end
            end

            // Simultaneous push and pop leaves the count unchanged.
            if (w_push && !w_pop)      r_fifo_count <= r_fifo_count + LP_CNT_ONE;
            else if (w_pop && !w_push) r_fifo_count <= r_fifo_count - LP_CNT_ONE;
        end
    end

    // FIFO storage needs no reset: entries are only read below the count.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= r_grant_port;
    end

    assign p0_ready         = r_p0_ready;
    assign p1_ready         = r_p1_ready;
    assign p0_rdata         = r_p0_rdata;
    assign p1_rdata         = r_p1_rdata;
    assign p0_rdata_valid   = r_p0_rdata_valid;
    assign p1_rdata_valid   = r_p1_rdata_valid;
    assign dram_address     = r_dram_address;
    assign dram_write       = r_dram_write;
    assign dram_valid       = r_dram_valid;
    assign dram_wdata       = r_dram_wdata;
    assign dram_wdata_mask  = r_dram_wdata_mask;
    assign o_dbg_state      = r_state;
    assign o_dbg_fifo_count = r_fifo_count;

endmodule
